// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the integer execute pipe (port 0) and the branch/AGU path (port 1).
// Round-robin grant on contention, one response register returned to the owning port.

package alu_share_arbiter_pkg;
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_SLL  = 5'd5,
    OP_SRL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_SLT  = 5'd8,
    OP_SLTU = 5'd9,
    OP_BEQ  = 5'd10,
    OP_BNE  = 5'd11,
    OP_BLT  = 5'd12,
    OP_BGE  = 5'd13,
    OP_BLTU = 5'd14,
    OP_BGEU = 5'd15
  } alu_operation_e;
endpackage

module alu_share_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0]  operand_a,
  input  logic [DW-1:0]  operand_b,
  input  alu_operation_e operation,
  output logic [DW-1:0]  result,
  output logic           branch
);

  logic [4:0] shamt;
  assign shamt = operand_b[4:0];

  // Arithmetic ops report only a result, compare-branches only a flag.
  always_comb begin
    result = '0;
    branch = 1'b0;
    case (operation)
      OP_ADD:  result = operand_a + operand_b;
      OP_SUB:  result = operand_a - operand_b;
      OP_AND:  result = operand_a & operand_b;
      OP_OR:   result = operand_a | operand_b;
      OP_XOR:  result = operand_a ^ operand_b;
      OP_SLL:  result = operand_a << shamt;
      OP_SRL:  result = operand_a >> shamt;
      OP_SRA:  result = $unsigned($signed(operand_a) >>> shamt);
      OP_SLT:  result = {{(DW-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: result = {{(DW-1){1'b0}}, (operand_a < operand_b)};
      OP_BEQ:  branch = (operand_a == operand_b);
      OP_BNE:  branch = (operand_a != operand_b);
      OP_BLT:  branch = ($signed(operand_a) < $signed(operand_b));
      OP_BGE:  branch = ($signed(operand_a) >= $signed(operand_b));
      OP_BLTU: branch = (operand_a < operand_b);
      OP_BGEU: branch = (operand_a >= operand_b);
      default: begin
        result = '0;
        branch = 1'b0;
      end
    endcase
  end

endmodule

module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0][DW-1:0]   req_operand_a,
  input  logic [1:0][DW-1:0]   req_operand_b,
  input  alu_operation_e [1:0] req_operation,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [DW-1:0]        rsp_result,
  output logic                 rsp_branch,
  output logic                 busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  rsp_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic          prio_q, prio_d;
  logic [DW-1:0] result_q, result_d;
  logic          branch_q, branch_d;

  logic          slot_free;
  logic          grant;
  logic          grant_idx;
  logic [DW-1:0] alu_result;
  logic          alu_branch;

  // A full slot still frees up in the same cycle its owner consumes it.
  always_comb begin
    slot_free = (state_q == EMPTY) || rsp_ready[owner_q];
    grant     = slot_free && (req_valid != 2'b00) && !reset;
    grant_idx = (req_valid == 2'b11) ? prio_q : req_valid[1];
  end

  alu_share_alu #(
    .DW(DW)
  ) u_alu (
    .operand_a (req_operand_a[grant_idx]),
    .operand_b (req_operand_b[grant_idx]),
    .operation (req_operation[grant_idx]),
    .result    (alu_result),
    .branch    (alu_branch)
  );

  always_comb begin
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    if (grant) req_ready = grant_idx ? 2'b10 : 2'b01;
    if (state_q == FULL) rsp_valid = owner_q ? 2'b10 : 2'b01;
    rsp_result = result_q;
    rsp_branch = branch_q;
    busy       = (state_q == FULL);
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    result_d = result_q;
    branch_d = branch_q;
    if (grant) begin
      state_d  = FULL;
      owner_d  = grant_idx;
      prio_d   = ~grant_idx;
      result_d = alu_result;
      branch_d = alu_branch;
    end else if (state_q == FULL && rsp_ready[owner_q]) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      result_q <= '0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      result_q <= result_d;
      branch_q <= branch_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: reset, directed vector table,
// multi-cycle corner sequences and a randomized run against a reference model.

module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][DW-1:0]   req_operand_a;
  logic [1:0][DW-1:0]   req_operand_b;
  alu_operation_e [1:0] req_operation;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [DW-1:0]        rsp_result;
  logic                 rsp_branch;
  logic                 busy;

  int compared   = 0;
  int mismatched = 0;

  alu_share_arbiter #(.DW(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_operand_a (req_operand_a),
    .req_operand_b (req_operand_b),
    .req_operation (req_operation),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_branch    (rsp_branch),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_operation_e op;
    logic [31:0]    a;
    logic [31:0]    b;
    logic [31:0]    res;
    logic           br;
  } vec_t;

  vec_t vecs[17];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input alu_operation_e op0, input logic [31:0] a0, input logic [31:0] b0,
                               input alu_operation_e op1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic [1:0] rdy);
    req_valid        = valid;
    req_operation[0] = op0;
    req_operand_a[0] = a0;
    req_operand_b[0] = b0;
    req_operation[1] = op1;
    req_operand_a[1] = a1;
    req_operand_b[1] = b1;
    rsp_ready        = rdy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    reset     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Reference ALU built from plain integer arithmetic on 64-bit values.
  function automatic void refAlu(input alu_operation_e op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic br);
    longint sa, sb, ua, ub, p;
    int unsigned sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sh = b % 32;
    p  = longint'(1) << sh;
    r  = 32'd0;
    br = 1'b0;
    case (op)
      OP_ADD:  r = 32'(ua + ub);
      OP_SUB:  r = 32'(ua - ub);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = 32'(ua * p);
      OP_SRL:  r = 32'(ua / p);
      OP_SRA:  r = (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: r = (ua < ub) ? 32'd1 : 32'd0;
      OP_BEQ:  br = (ua == ub);
      OP_BNE:  br = (ua != ub);
      OP_BLT:  br = (sa < sb);
      OP_BGE:  br = (sa >= sb);
      OP_BLTU: br = (ua < ub);
      OP_BGEU: br = (ua >= ub);
      default: begin
        r  = 32'd0;
        br = 1'b0;
      end
    endcase
  endfunction

  logic           p_valid[2];
  alu_operation_e p_op[2];
  logic [31:0]    p_a[2];
  logic [31:0]    p_b[2];

  initial begin
    logic        m_full, m_owner, m_prio, m_br, m_free, m_grant;
    logic [31:0] m_res;
    int          g, prevg;
    logic [1:0]  exp_ready, exp_valid;

    vecs[0]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    vecs[3]  = '{OP_OR,   32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
    vecs[4]  = '{OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    vecs[5]  = '{OP_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0};
    vecs[6]  = '{OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
    vecs[7]  = '{OP_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0};
    vecs[8]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[9]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[10] = '{OP_BEQ,  32'h00001234, 32'h00001234, 32'h00000000, 1'b1};
    vecs[11] = '{OP_BNE,  32'h00001234, 32'h00001234, 32'h00000000, 1'b0};
    vecs[12] = '{OP_BLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[13] = '{OP_BGE,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[14] = '{OP_BGEU, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[15] = '{OP_BLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[16] = '{alu_operation_e'(5'd20), 32'h00000005, 32'h00000006, 32'h00000000, 1'b0};

    // Reset held with both requesters valid: nothing may be granted or returned.
    reset = 1'b1;
    applyStimulus(2'b11, OP_ADD, 32'hFFFFFFFF, 32'd2, OP_BLT, 32'hFFFFFFFF, 32'd1, 2'b11);
    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rsp_result", rsp_result, 32'd0);
    checkOutput("reset_rsp_branch", 32'(rsp_branch), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("first_grant_port0", 32'(req_ready), 32'b01);
    tick();
    @(negedge clk);
    checkOutput("first_rsp_valid", 32'(rsp_valid), 32'b01);
    checkOutput("first_rsp_result", rsp_result, 32'h00000001);
    checkOutput("first_rsp_branch", 32'(rsp_branch), 32'd0);
    checkOutput("second_grant_port1", 32'(req_ready), 32'b10);
    tick();

    // Directed vector table through port 0.
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(2'b01, vecs[i].op, vecs[i].a, vecs[i].b, OP_ADD, 32'd0, 32'd0, 2'b01);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'b01);
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'b01);
      checkOutput($sformatf("vec%0d_result", i), rsp_result, vecs[i].res);
      checkOutput($sformatf("vec%0d_branch", i), 32'(rsp_branch), 32'(vecs[i].br));
      tick();
    end

    // Contention with both consumers ready: grants alternate, one response per cycle.
    doReset();
    applyStimulus(2'b11, OP_SUB, 32'd5, 32'd7, OP_BLT, 32'hFFFFFFFF, 32'd1, 2'b11);
    prevg = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      g = c % 2;
      checkOutput($sformatf("alt%0d_req_ready", c), 32'(req_ready), (g == 1) ? 32'b10 : 32'b01);
      if (c > 0) begin
        checkOutput($sformatf("alt%0d_rsp_valid", c), 32'(rsp_valid), (prevg == 1) ? 32'b10 : 32'b01);
        checkOutput($sformatf("alt%0d_result", c), rsp_result, (prevg == 1) ? 32'd0 : 32'hFFFFFFFE);
        checkOutput($sformatf("alt%0d_branch", c), 32'(rsp_branch), (prevg == 1) ? 32'd1 : 32'd0);
      end
      prevg = g;
      tick();
    end

    // Back-pressure on port 1; port 0's ready is high but must be ignored.
    doReset();
    applyStimulus(2'b10, OP_ADD, 32'd3, 32'd4, OP_SRA, 32'h80000000, 32'h24, 2'b00);
    @(negedge clk);
    checkOutput("bp_grant_port1", 32'(req_ready), 32'b10);
    tick();
    applyStimulus(2'b01, OP_ADD, 32'd3, 32'd4, OP_SRA, 32'h80000000, 32'h24, 2'b01);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'b00);
      checkOutput($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid), 32'b10);
      checkOutput($sformatf("bp%0d_result", c), rsp_result, 32'hF8000000);
      checkOutput($sformatf("bp%0d_busy", c), 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    checkOutput("bp_passthrough_grant", 32'(req_ready), 32'b01);
    checkOutput("bp_drain_rsp_valid", 32'(rsp_valid), 32'b10);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("bp_next_rsp_valid", 32'(rsp_valid), 32'b01);
    checkOutput("bp_next_result", rsp_result, 32'd7);
    tick();

    // Reset while a response is held and stalled.
    doReset();
    applyStimulus(2'b10, OP_ADD, 32'd10, 32'd20, OP_SRA, 32'h80000000, 32'h24, 2'b00);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("midrst_busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'b00);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_result", rsp_result, 32'd0);
    applyStimulus(2'b11, OP_ADD, 32'd10, 32'd20, OP_BLT, 32'hFFFFFFFF, 32'd1, 2'b11);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_prio0_grant", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("midrst_rsp_valid_after", 32'(rsp_valid), 32'b01);
    checkOutput("midrst_result_after", rsp_result, 32'd30);
    tick();

    // Randomized traffic against the reference model.
    doReset();
    m_full = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_res = 32'd0; m_br = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_valid[i] = 1'b0; p_op[i] = OP_ADD; p_a[i] = 32'd0; p_b[i] = 32'd0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_valid[i] && $urandom_range(0, 99) < 60) begin
          int unsigned v;
          v = $urandom_range(0, 17);
          p_valid[i] = 1'b1;
          p_op[i]    = alu_operation_e'((v < 16) ? 5'(v) : 5'(v + 8));
          p_b[i]     = $urandom();
          p_a[i]     = ($urandom_range(0, 3) == 0) ? p_b[i] : $urandom();
        end
        req_valid[i]     = p_valid[i];
        req_operation[i] = p_op[i];
        req_operand_a[i] = p_a[i];
        req_operand_b[i] = p_b[i];
        rsp_ready[i]     = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      m_free  = !m_full || rsp_ready[m_owner];
      m_grant = m_free && (p_valid[0] || p_valid[1]);
      g       = (p_valid[0] && p_valid[1]) ? int'(m_prio) : (p_valid[1] ? 1 : 0);
      exp_ready = m_grant ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_valid = m_full ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      checkOutput($sformatf("rnd%0d_req_ready", c), 32'(req_ready), 32'(exp_ready));
      checkOutput($sformatf("rnd%0d_rsp_valid", c), 32'(rsp_valid), 32'(exp_valid));
      checkOutput($sformatf("rnd%0d_result", c), rsp_result, m_res);
      checkOutput($sformatf("rnd%0d_branch", c), 32'(rsp_branch), 32'(m_br));
      checkOutput($sformatf("rnd%0d_busy", c), 32'(busy), 32'(m_full));
      tick();
      if (m_grant) begin
        refAlu(p_op[g], p_a[g], p_b[g], m_res, m_br);
        m_full     = 1'b1;
        m_owner    = (g == 1);
        m_prio     = (g == 0);
        p_valid[g] = 1'b0;
      end else if (m_full && rsp_ready[m_owner]) begin
        m_full = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
